// File: rtl/lvds_link_pkg.sv
// rtl/lvds_link_pkg.sv - LVDS link symbols, FSM state types and parameter defaults
package lvds_link_pkg;

  localparam logic [15:0] IDLE_SYM   = 16'hF0F0;
  localparam logic [15:0] SOF_SYM    = 16'hFB5A;
  localparam logic [7:0]  TRAIN_BYTE = 8'hF0;

  localparam int LOCK_COUNT_DEF  = 16;
  localparam int SLIP_SETTLE_DEF = 4;
  localparam int FIFO_DEPTH_DEF  = 4;
  localparam int LOSS_COUNT_DEF  = 4;

  typedef enum logic {
    TRAIN   = 1'b0,
    ALIGNED = 1'b1
  } link_state_t;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_HI   = 2'd1,
    F_LO   = 2'd2
  } frame_state_t;

endpackage

// File: rtl/lvds_rx_fifo.sv
// rtl/lvds_rx_fifo.sv - synchronous first-word-fall-through word FIFO
// A push while full is accepted only when a pop is taken in the same cycle.
module lvds_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Empty reads as zero so the head output has a defined reset value.
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/lvds_rx_deframer.sv
// rtl/lvds_rx_deframer.sv - two-lane LVDS bitslip alignment, SOF/hi/lo deframing, word FIFO
// Optional illegal-symbol/slip counter on err_count under LVDS_RX_ERRCNT_EN.
module lvds_rx_deframer
  import lvds_link_pkg::*;
#(
  parameter int LOCK_COUNT  = LOCK_COUNT_DEF,
  parameter int SLIP_SETTLE = SLIP_SETTLE_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int LOSS_COUNT  = LOSS_COUNT_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] rx_data,
  output logic [1:0]  rx_bitslip,
  output logic        rx_align_done,
  output logic [31:0] deq_rx,
  input  logic        EN_deq_rx,
  output logic        RDY_deq_rx,
  output logic        overflow,
  output logic [15:0] err_count
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int SW = $clog2(SLIP_SETTLE + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam logic [MW-1:0] LOCK_MAX   = MW'(LOCK_COUNT);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SLIP_SETTLE);
  localparam logic [LW-1:0] LOSS_LAST  = LW'(LOSS_COUNT - 1);

  link_state_t  r_link_state;
  link_state_t  w_link_next;
  frame_state_t r_frm_state;
  frame_state_t w_frm_next;

  logic          w_train;
  logic          w_aligned;
  logic [1:0]    w_lane_locked;
  logic [1:0]    w_slip_set;
  logic          w_illegal;
  logic          w_legal_idle;
  logic          w_latch_hi;
  logic          w_push;
  logic          w_loss;
  logic [LW-1:0] r_ill_cnt;
  logic [15:0]   r_hi;
  logic          r_overflow;
  logic          w_full;
  logic          w_empty;
  logic          w_drop;

  assign w_train   = (r_link_state == TRAIN);
  assign w_aligned = (r_link_state == ALIGNED);

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [MW-1:0] r_match;
    logic [SW-1:0] r_settle;
    logic          r_slip;
    logic          w_hit;

    assign w_hit            = (rx_data[g*8 +: 8] == TRAIN_BYTE);
    assign w_slip_set[g]    = w_train && !w_hit && (r_settle == '0);
    assign w_lane_locked[g] = (r_match == LOCK_MAX);
    assign rx_bitslip[g]    = r_slip;

    always_ff @(posedge CLK) begin
      if (RST || w_loss) begin
        r_match  <= '0;
        r_settle <= '0;
        r_slip   <= 1'b0;
      end else if (w_train) begin
        r_slip <= w_slip_set[g];
        if (w_hit) begin
          if (r_match != LOCK_MAX) r_match <= r_match + MW'(1);
          if (r_settle != '0)      r_settle <= r_settle - SW'(1);
        end else begin
          r_match  <= '0;
          r_settle <= (r_settle == '0) ? SETTLE_MAX : r_settle - SW'(1);
        end
      end else begin
        r_slip <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) r_link_state <= TRAIN;
    else     r_link_state <= w_link_next;
  end

  always_comb begin
    w_link_next = r_link_state;
    case (r_link_state)
      TRAIN:   if (&w_lane_locked) w_link_next = ALIGNED;
      ALIGNED: if (w_loss)         w_link_next = TRAIN;
      default: w_link_next = TRAIN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_frm_state <= F_IDLE;
    else     r_frm_state <= w_frm_next;
  end

  always_comb begin
    w_frm_next = r_frm_state;
    if (!w_aligned) begin
      w_frm_next = F_IDLE;
    end else begin
      case (r_frm_state)
        F_IDLE:  if (rx_data == SOF_SYM) w_frm_next = F_HI;
        F_HI:    w_frm_next = F_LO;
        F_LO:    w_frm_next = F_IDLE;
        default: w_frm_next = F_IDLE;
      endcase
    end
  end

  always_comb begin
    w_illegal    = 1'b0;
    w_legal_idle = 1'b0;
    w_latch_hi   = 1'b0;
    w_push       = 1'b0;
    if (w_aligned) begin
      case (r_frm_state)
        F_IDLE: begin
          w_illegal    = (rx_data != IDLE_SYM) && (rx_data != SOF_SYM);
          w_legal_idle = !w_illegal;
        end
        F_HI:    w_latch_hi = 1'b1;
        F_LO:    w_push     = 1'b1;
        default: ;
      endcase
    end
  end

  // The final illegal symbol of a run triggers the drop back to training directly.
  assign w_loss = w_illegal && (r_ill_cnt == LOSS_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ill_cnt <= '0;
      r_hi      <= '0;
    end else begin
      if (w_legal_idle || w_loss) r_ill_cnt <= '0;
      else if (w_illegal)         r_ill_cnt <= r_ill_cnt + LW'(1);
      if (w_latch_hi) r_hi <= rx_data;
    end
  end

  lvds_rx_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_push),
    .i_data  ({r_hi, rx_data}),
    .i_pop   (EN_deq_rx),
    .o_data  (deq_rx),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign RDY_deq_rx = !w_empty;
  assign w_drop     = w_push && w_full && !(EN_deq_rx && !w_empty);

  always_ff @(posedge CLK) begin
    if (RST)         r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  assign overflow      = r_overflow;
  assign rx_align_done = w_aligned;

`ifdef LVDS_RX_ERRCNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge CLK) begin
    if (RST)
      r_err_cnt <= '0;
    else if ((w_illegal || (|w_slip_set)) && (r_err_cnt != 16'hFFFF))
      r_err_cnt <= r_err_cnt + 16'd1;
  end

  assign err_count = r_err_cnt;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_lvds_rx_deframer.sv
// tb/tb_lvds_rx_deframer.sv - directed self-checking bench for lvds_rx_deframer
module tb_lvds_rx_deframer;
  import lvds_link_pkg::*;

`ifdef LVDS_RX_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] rx_data;
  logic [1:0]  rx_bitslip;
  logic        rx_align_done;
  logic [31:0] deq_rx;
  logic        EN_deq_rx = 1'b0;
  logic        RDY_deq_rx;
  logic        overflow;
  logic [15:0] err_count;

  logic [15:0] tx_sym = IDLE_SYM;
  int rot0 = 0;
  int rot1 = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // Deserializer model: each lane's byte is the sent byte rotated by its slip offset.
  assign rx_data = {rotl(tx_sym[15:8], rot1), rotl(tx_sym[7:0], rot0)};

  lvds_rx_deframer #(
    .LOCK_COUNT  (16),
    .SLIP_SETTLE (4),
    .FIFO_DEPTH  (4),
    .LOSS_COUNT  (4)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .rx_data       (rx_data),
    .rx_bitslip    (rx_bitslip),
    .rx_align_done (rx_align_done),
    .deq_rx        (deq_rx),
    .EN_deq_rx     (EN_deq_rx),
    .RDY_deq_rx    (RDY_deq_rx),
    .overflow      (overflow),
    .err_count     (err_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (rx_bitslip[0]) rot0 = (rot0 + 1) % 8;
    if (rx_bitslip[1]) rot1 = (rot1 + 1) % 8;
  endtask

  task automatic do_reset(input int r0);
    RST = 1'b1; EN_deq_rx = 1'b0; tx_sym = IDLE_SYM; rot0 = r0; rot1 = 0;
    step(); step();
    RST = 1'b0;
  endtask

  task automatic align_fresh();
    do_reset(0);
    for (int i = 0; i < 17; i++) step();
    check("align_fresh", {31'd0, rx_align_done}, 32'd1);
  endtask

  task automatic send_frame(input logic [31:0] w, input logic pop_on_lo);
    tx_sym = SOF_SYM;  step();
    tx_sym = w[31:16]; step();
    tx_sym = w[15:0];  EN_deq_rx = pop_on_lo; step();
    EN_deq_rx = 1'b0;  tx_sym = IDLE_SYM;
  endtask

  task automatic deq_one();
    EN_deq_rx = 1'b1; step(); EN_deq_rx = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int slips;
    int l1_slips;
    int align_edge;
    int slip_at[$];

    // Reset values and clean training from continuous idle
    do_reset(0);
    check("rst_bitslip", {30'd0, rx_bitslip}, 32'd0);
    check("rst_align", {31'd0, rx_align_done}, 32'd0);
    check("rst_rdy", {31'd0, RDY_deq_rx}, 32'd0);
    check("rst_deq", deq_rx, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_err", {16'd0, err_count}, 32'd0);
    slips = 0;
    for (int e = 1; e <= 17; e++) begin
      step();
      if (rx_bitslip != 2'b00) slips++;
      if (e == 16) check("align_e16", {31'd0, rx_align_done}, 32'd0);
      if (e == 17) check("align_e17", {31'd0, rx_align_done}, 32'd1);
    end
    check("train_no_slips", slips, 32'd0);
    check("train_rdy", {31'd0, RDY_deq_rx}, 32'd0);

    // Two frames buffered, no dequeue
    tx_sym = SOF_SYM;   step();
    tx_sym = 16'hDEAD;  step();
    check("rdy_before_lo", {31'd0, RDY_deq_rx}, 32'd0);
    tx_sym = 16'hBEEF;  step();
    check("rdy_after_lo", {31'd0, RDY_deq_rx}, 32'd1);
    check("word0_head", deq_rx, 32'hDEADBEEF);
    tx_sym = IDLE_SYM;
    send_frame(32'h12345678, 1'b0);
    step();
    check("word0_still", deq_rx, 32'hDEADBEEF);
    deq_one();
    check("word1_head", deq_rx, 32'h12345678);
    check("word1_rdy", {31'd0, RDY_deq_rx}, 32'd1);
    deq_one();
    check("drained_rdy", {31'd0, RDY_deq_rx}, 32'd0);
    check("drained_deq", deq_rx, 32'd0);
    deq_one();
    check("deq_empty_rdy", {31'd0, RDY_deq_rx}, 32'd0);

    // Lane 0 rotated by 3 bits: five slips at edges 1,6,11,16,21, lock at 37, aligned at 38
    do_reset(3);
    l1_slips = 0; align_edge = -1; slip_at.delete();
    for (int e = 1; e <= 60 && align_edge < 0; e++) begin
      step();
      if (rx_bitslip[0]) slip_at.push_back(e);
      if (rx_bitslip[1]) l1_slips++;
      if (rx_align_done) align_edge = e;
    end
    check("slip_count", slip_at.size(), 32'd5);
    for (int i = 0; i < slip_at.size() && i < 5; i++)
      check($sformatf("slip_edge%0d", i), slip_at[i], 1 + 5 * i);
    check("lane1_slips", l1_slips, 32'd0);
    check("rot_align_edge", align_edge, 32'd38);
    check("rot_err", {16'd0, err_count}, ERRCNT ? 32'd5 : 32'd0);

    // Five frames, no dequeue: fifth dropped
    align_fresh();
    for (int i = 0; i < 4; i++) send_frame({16'hA000 + 16'(i), 16'h0B00 + 16'(i)}, 1'b0);
    step();
    check("full_no_ovf", {31'd0, overflow}, 32'd0);
    send_frame(32'hA0040B04, 1'b0);
    step();
    check("ovf_set", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_word%0d", i), deq_rx, {16'hA000 + 16'(i), 16'h0B00 + 16'(i)});
      deq_one();
    end
    check("ovf_drained", {31'd0, RDY_deq_rx}, 32'd0);

    // Five frames, dequeue on the fifth lo: accepted
    align_fresh();
    for (int i = 0; i < 4; i++) send_frame({16'hA000 + 16'(i), 16'h0B00 + 16'(i)}, 1'b0);
    send_frame(32'hA0040B04, 1'b1);
    step();
    check("pop_push_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 1; i < 5; i++) begin
      check($sformatf("pp_word%0d", i), deq_rx, {16'hA000 + 16'(i), 16'h0B00 + 16'(i)});
      deq_one();
    end
    check("pp_drained", {31'd0, RDY_deq_rx}, 32'd0);

    // Loss of alignment after four illegal symbols; buffered words survive
    align_fresh();
    send_frame(32'h11112222, 1'b0);
    send_frame(32'h33334444, 1'b0);
    tx_sym = 16'h0000;
    step(); step(); step();
    check("loss_third", {31'd0, rx_align_done}, 32'd1);
    step();
    tx_sym = IDLE_SYM;
    check("loss_fourth", {31'd0, rx_align_done}, 32'd0);
    check("loss_err", {16'd0, err_count}, ERRCNT ? 32'd4 : 32'd0);
    check("loss_rdy", {31'd0, RDY_deq_rx}, 32'd1);
    check("loss_word0", deq_rx, 32'h11112222);
    deq_one();
    check("loss_word1", deq_rx, 32'h33334444);
    deq_one();
    check("loss_drained", {31'd0, RDY_deq_rx}, 32'd0);

    // Reset between hi and lo discards everything
    align_fresh();
    send_frame(32'hCAFE0001, 1'b0);
    tx_sym = SOF_SYM;  step();
    tx_sym = 16'h7777; step();
    RST = 1'b1; tx_sym = 16'h8888; step();
    check("mid_rst_rdy", {31'd0, RDY_deq_rx}, 32'd0);
    check("mid_rst_deq", deq_rx, 32'd0);
    check("mid_rst_align", {31'd0, rx_align_done}, 32'd0);
    check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    check("mid_rst_err", {16'd0, err_count}, 32'd0);
    RST = 1'b0; tx_sym = IDLE_SYM;
    for (int i = 0; i < 5; i++) step();
    check("post_rst_rdy", {31'd0, RDY_deq_rx}, 32'd0);
    check("post_rst_deq", deq_rx, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
